token_fifo_sync: RTL and testbench

TOKEN_FIFO_SYNC -- requirements
Module: token_fifo_sync

---
 rtl/token_fifo_pkg.sv | 18 +
 rtl/token_ring_sync.sv | 37 +++
 rtl/token_fifo_sync.sv | 108 ++++++++++
 tb/tb_token_fifo_sync.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/token_fifo_pkg.sv
// Shared definitions for the token-ring FIFO: one-hot rotate helper and token reset value.
package token_fifo_pkg;

   // Widest ring the helper supports; rings of DEPTH <= MaxDepth use the low bits.
   localparam int unsigned MaxDepth = 32;

   typedef logic [MaxDepth-1:0] tok_t;

   localparam tok_t TokReset = tok_t'(1);

   // Rotate a one-hot token up by one inside the window given by mask (low-aligned ones).
   function automatic tok_t rotate_1h(input tok_t tok, input tok_t mask);
      tok_t top;
      top = tok & ~(mask >> 1);
      return ((tok << 1) & mask) | tok_t'(|top);
   endfunction

endpackage

// File: rtl/token_ring_sync.sv
// DEPTH-bit one-hot rotating token register; advances by one position when adv is high.
module token_ring_sync
   import token_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             init,
   input  logic             adv,
   output logic [DEPTH-1:0] tok
);

   localparam tok_t Mask = {MaxDepth{1'b1}} >> (MaxDepth - DEPTH);

   logic [DEPTH-1:0] tok_q, tok_d;
   tok_t             rot;
   logic             unused_rot;

   always_comb begin
      rot   = rotate_1h(tok_t'(tok_q), Mask);
      tok_d = adv ? rot[DEPTH-1:0] : tok_q;
   end

   // Bits above DEPTH are always zero after masking.
   assign unused_rot = ^rot;

   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         tok_q <= TokReset[DEPTH-1:0];
      end else begin
         tok_q <= tok_d;
      end
   end

   assign tok = tok_q;

endmodule

// File: rtl/token_fifo_sync.sv
// Single-clock FIFO addressed by one-hot put/get token rings with per-cell valid bits.
// Define TOKEN_FIFO_SYNC_ALMOST_EN to add almost_full/almost_empty from an occupancy counter.
module token_fifo_sync
   import token_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             init,
   input  logic             en_put,
   input  logic [WIDTH-1:0] data_put,
   output logic             full,
   input  logic             en_get,
   output logic [WIDTH-1:0] data_get,
   output logic             valid_get,
   output logic             empty,
   output logic [DEPTH-1:0] tok_put,
   output logic [DEPTH-1:0] tok_get
`ifdef TOKEN_FIFO_SYNC_ALMOST_EN
   ,
   output logic             almost_full,
   output logic             almost_empty
`endif
);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [WIDTH-1:0] data_get_q, rd_word;
   logic             valid_get_q;
   logic             put_acc, get_acc;

   token_ring_sync #(
      .DEPTH (DEPTH)
   ) u_put_ring (
      .clk  (clk),
      .init (init),
      .adv  (put_acc),
      .tok  (tok_put)
   );

   token_ring_sync #(
      .DEPTH (DEPTH)
   ) u_get_ring (
      .clk  (clk),
      .init (init),
      .adv  (get_acc),
      .tok  (tok_get)
   );

   // Flags come from registered state only; no combinational path from the enables.
   assign full    = |(tok_put & valid_q);
   assign empty   = ~|(tok_get & valid_q);
   assign put_acc = en_put & ~full;
   assign get_acc = en_get & ~empty;

   always_comb begin
      valid_d = valid_q;
      rd_word = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (put_acc && tok_put[i]) valid_d[i] = 1'b1;
         if (get_acc && tok_get[i]) valid_d[i] = 1'b0;
         if (tok_get[i]) rd_word = rd_word | data_q[i];
      end
   end

   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         valid_q     <= '0;
         data_get_q  <= '0;
         valid_get_q <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         valid_get_q <= get_acc;
         if (get_acc) data_get_q <= rd_word;
      end
   end

   // Cell storage carries no reset; the valid bits alone define occupancy.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (put_acc && tok_put[i]) data_q[i] <= data_put;
      end
   end

   assign data_get  = data_get_q;
   assign valid_get = valid_get_q;

`ifdef TOKEN_FIFO_SYNC_ALMOST_EN
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [CntW-1:0] cnt_q;

   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         cnt_q <= '0;
      end else if (put_acc && !get_acc) begin
         cnt_q <= cnt_q + 1'b1;
      end else if (get_acc && !put_acc) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign almost_full  = (cnt_q >= CntW'(DEPTH - 1));
   assign almost_empty = (cnt_q <= CntW'(1));
`endif

endmodule

// File: tb/tb_token_fifo_sync.sv
// Scoreboard bench for token_fifo_sync (WIDTH=8, DEPTH=4) with directed vectors.
module tb_token_fifo_sync;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;

   logic             clk = 1'b0;
   logic             init;
   logic             en_put;
   logic [WIDTH-1:0] data_put;
   logic             full;
   logic             en_get;
   logic [WIDTH-1:0] data_get;
   logic             valid_get;
   logic             empty;
   logic [DEPTH-1:0] tok_put;
   logic [DEPTH-1:0] tok_get;
`ifdef TOKEN_FIFO_SYNC_ALMOST_EN
   logic             almost_full;
   logic             almost_empty;
`endif

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] model_q [$];
   logic [WIDTH-1:0] exp_q   [$];

   token_fifo_sync #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .init         (init),
      .en_put       (en_put),
      .data_put     (data_put),
      .full         (full),
      .en_get       (en_get),
      .data_get     (data_get),
      .valid_get    (valid_get),
      .empty        (empty),
      .tok_put      (tok_put),
      .tok_get      (tok_get)
`ifdef TOKEN_FIFO_SYNC_ALMOST_EN
      ,
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Drive one cycle; the model decides acceptance from its own occupancy.
   task automatic step(input logic p, input logic [WIDTH-1:0] d, input logic g);
      logic put_ok, get_ok;
      en_put   = p;
      data_put = d;
      en_get   = g;
      put_ok   = p && (model_q.size() < DEPTH);
      get_ok   = g && (model_q.size() > 0);
      @(posedge clk);
      if (get_ok) exp_q.push_back(model_q.pop_front());
      if (put_ok) model_q.push_back(d);
      #1;
      en_put = 1'b0;
      en_get = 1'b0;
   endtask

   // Monitor: every presented word must match the oldest expected word.
   initial begin
      forever begin
         @(negedge clk);
         if (!init) begin
            chk("tok_put_onehot", 32'($onehot(tok_put)), 32'd1);
            chk("tok_get_onehot", 32'($onehot(tok_get)), 32'd1);
         end
         if (valid_get) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid_get", 32'(valid_get), 32'd0);
            end else begin
               chk("sb_data_get", 32'(data_get), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      logic [WIDTH-1:0] fill_vals [4];
      fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      init     = 1'b1;
      en_put   = 1'b0;
      en_get   = 1'b0;
      data_put = '0;

      // Reset is asynchronous: checked before the first clock edge.
      #2;
      chk("rst_tok_put", 32'(tok_put), 32'h1);
      chk("rst_tok_get", 32'(tok_get), 32'h1);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_valid_get", 32'(valid_get), 32'd0);
      chk("rst_data_get", 32'(data_get), 32'h0);
`ifdef TOKEN_FIFO_SYNC_ALMOST_EN
      chk("rst_almost_empty", 32'(almost_empty), 32'd1);
      chk("rst_almost_full", 32'(almost_full), 32'd0);
`endif
      @(negedge clk);
      init = 1'b0;

      // Fill
      step(1'b1, 8'h11, 1'b0);
      chk("put1_empty", 32'(empty), 32'd0);
      chk("put1_tok_put", 32'(tok_put), 32'h2);
      step(1'b1, 8'h22, 1'b0);
      step(1'b1, 8'h33, 1'b0);
      step(1'b1, 8'h44, 1'b0);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_tok_put", 32'(tok_put), 32'h1);
      chk("fill_tok_get", 32'(tok_get), 32'h1);
`ifdef TOKEN_FIFO_SYNC_ALMOST_EN
      chk("fill_almost_full", 32'(almost_full), 32'd1);
      chk("fill_almost_empty", 32'(almost_empty), 32'd0);
`endif
      step(1'b1, 8'h55, 1'b0);
      chk("rej_put_tok_put", 32'(tok_put), 32'h1);
      chk("rej_put_full", 32'(full), 32'd1);

      // Drain
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 8'h00, 1'b1);
         chk("drain_valid_get", 32'(valid_get), 32'd1);
         chk("drain_data_get", 32'(data_get), 32'(fill_vals[k]));
      end
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_tok_get", 32'(tok_get), 32'h1);
      step(1'b0, 8'h00, 1'b1);
      chk("rej_get_valid_get", 32'(valid_get), 32'd0);
      chk("rej_get_data_hold", 32'(data_get), 32'h44);
      chk("rej_get_tok_get", 32'(tok_get), 32'h1);

      // Wrap: 6 puts, 6 gets interleaved
      step(1'b1, 8'hA1, 1'b0);
      for (int k = 2; k <= 6; k++) begin
         step(1'b1, 8'hA0 + 8'(k), 1'b1);
         chk("wrap_valid_get", 32'(valid_get), 32'd1);
      end
      step(1'b0, 8'h00, 1'b1);
      chk("wrap_tok_put", 32'(tok_put), 32'h4);
      chk("wrap_tok_get", 32'(tok_get), 32'h4);
      chk("wrap_empty", 32'(empty), 32'd1);

      // Simultaneous put/get at full
      for (int k = 1; k <= 4; k++) step(1'b1, 8'hB0 + 8'(k), 1'b0);
      chk("full2_full", 32'(full), 32'd1);
      step(1'b1, 8'hBF, 1'b1);
      chk("simfull_data_get", 32'(data_get), 32'hB1);
      chk("simfull_valid_get", 32'(valid_get), 32'd1);
      chk("simfull_full", 32'(full), 32'd0);
      chk("simfull_tok_put", 32'(tok_put), 32'h4);
      chk("simfull_tok_get", 32'(tok_get), 32'h8);
      for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1);
      chk("simfull_drained_empty", 32'(empty), 32'd1);

      // Simultaneous put/get at empty
      step(1'b1, 8'hC1, 1'b1);
      chk("simempty_valid_get", 32'(valid_get), 32'd0);
      chk("simempty_empty", 32'(empty), 32'd0);

      // init mid-cycle with 3 words stored
      step(1'b1, 8'hC2, 1'b0);
      step(1'b1, 8'hC3, 1'b0);
      #2;
      init = 1'b1;
      #1;
      chk("midinit_empty", 32'(empty), 32'd1);
      chk("midinit_full", 32'(full), 32'd0);
      chk("midinit_tok_put", 32'(tok_put), 32'h1);
      chk("midinit_tok_get", 32'(tok_get), 32'h1);
      chk("midinit_data_get", 32'(data_get), 32'h0);
`ifdef TOKEN_FIFO_SYNC_ALMOST_EN
      chk("midinit_almost_empty", 32'(almost_empty), 32'd1);
`endif
      model_q.delete();
      @(negedge clk);
      init = 1'b0;

      // Stale words must be gone
      step(1'b1, 8'hD1, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      chk("post_init_data_get", 32'(data_get), 32'hD1);
      chk("post_init_empty", 32'(empty), 32'd1);

      @(negedge clk);
      @(negedge clk);
      chk("sb_all_consumed", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
